piso_word_tx: RTL and testbench

Word-level serialiser that sits directly upstream of the parallel-in serial-out shift stage and replaces manual `set`/`advance` sequencing. It accepts WIDTH-bit words over a valid/ready handshake, then emits them LSB-first on a single serial line, holding each bit for a programmable number of clocks and framing the transfer. It provides the full handshake, bit pacing, frame, completion and abort behaviour that the bare shift register lacks.

---
 rtl/serial_pkg.sv | 16 +
 rtl/bit_tick_gen.sv | 45 ++++
 rtl/piso_word_tx.sv | 116 +++++++++++
 tb/tb_piso_word_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the word serialiser.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width that still gives a 1-bit register when n <= 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Modulo-CLKS_PER_BIT tick counter that paces how long each serial bit is held.
// Latency: wrap_o is combinational from the count register and en_i.
// Backpressure: none; counts whenever en_i is high, clr_i forces the count to 0.
//
// Ports: clk_i/rst_ni clock and async active-low reset; en_i advance the count;
//        clr_i synchronous clear (wins over en_i); wrap_o high in the last clock of a bit.
module bit_tick_gen
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int             TW   = cnt_w(CLKS_PER_BIT);
    localparam logic [TW-1:0]  LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // With CLKS_PER_BIT==1 LAST is 0, so every enabled clock is a wrap.
    assign wrap_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_word_tx.sv
// Word serialiser: takes WIDTH-bit words on valid/ready and sends them LSB-first on bit_o.
// Latency: bit 0 appears the cycle after the handshake; done_o pulses WIDTH*CLKS_PER_BIT+1 cycles after it.
// Backpressure: ready_o high only in IDLE or in the last clock of the last bit (no abort), so frames chain gap-free.
//
// Ports: clk_i/rst_ni clock and async active-low reset; data_i/valid_i/ready_o word handshake;
//        abort_i kill the current frame; bit_o serial data; frame_o high during frame bits;
//        done_o one-cycle pulse after a normally completed frame.
module piso_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit COVER        = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             abort_i,
    output logic             bit_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int BW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             bit_q, frame_q, done_q;
    logic             done_d;

    logic tick_wrap;
    logic last_tick;
    logic xfer;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q == SHIFT),
        .clr_i  ((state_q == IDLE) || abort_i),
        .wrap_o (tick_wrap)
    );

    // Last clock of the last bit: the only SHIFT cycle that may take the next word.
    assign last_tick = (state_q == SHIFT) && (bit_cnt_q == '0) && tick_wrap;
    assign ready_o   = (state_q == IDLE) || (last_tick && !abort_i);
    assign xfer      = valid_i && ready_o;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d   = SHIFT;
                    shreg_d   = data_i;
                    bit_cnt_d = BW'(WIDTH - 1);
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                    shreg_d = '0;
                end else if (tick_wrap) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    if (bit_cnt_q == '0) begin
                        done_d = 1'b1;
                        if (xfer) begin
                            shreg_d   = data_i;
                            bit_cnt_d = BW'(WIDTH - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            bit_q     <= 1'b0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            bit_q     <= (state_d == SHIFT) && shreg_d[0];
            frame_q   <= (state_d == SHIFT);
            done_q    <= done_d;
        end
    end

    assign bit_o   = bit_q;
    assign frame_o = frame_q;
    assign done_o  = done_q;

    if (COVER) begin : g_cover
        cover property (@(posedge clk_i) disable iff (!rst_ni) done_o && frame_o);
        cover property (@(posedge clk_i) disable iff (!rst_ni) frame_o && abort_i);
    end

endmodule

// File: tb/tb_piso_word_tx.sv
// Bench for piso_word_tx: two instances (8 bits x 4 clocks, 4 bits x 1 clock) against a frame-timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_piso_word_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] d0;
    logic       v0, a0, r0, b0, f0, dn0;
    logic [3:0] d1;
    logic       v1, a1, r1, b1, f1, dn1;

    piso_word_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .COVER(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(d0), .valid_i(v0), .ready_o(r0),
        .abort_i(a0), .bit_o(b0), .frame_o(f0), .done_o(dn0)
    );

    piso_word_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .COVER(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(d1), .valid_i(v1), .ready_o(r1),
        .abort_i(a1), .bit_o(b1), .frame_o(f1), .done_o(dn1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a frame is a word plus the index of the current cycle within it
    // (1..WIDTH*CLKS_PER_BIT); 0 means idle.
    int         WW[2] = '{8, 4};
    int         CC[2] = '{4, 1};
    int         el[2];
    logic [7:0] wd[2];
    int         mdone[2];

    function automatic int m_ready(input int i, input logic ab);
        return ((el[i] == 0) || (el[i] == WW[i] * CC[i] && !ab)) ? 1 : 0;
    endfunction

    function automatic int m_bit(input int i);
        if (el[i] == 0) return 0;
        return int'(wd[i][(el[i] - 1) / CC[i]]);
    endfunction

    task automatic m_edge(input int i, input logic vv, input logic aa, input logic [7:0] dd);
        logic xf;
        xf = vv && (m_ready(i, aa) == 1);
        mdone[i] = 0;
        if (el[i] == 0) begin
            if (xf) begin el[i] = 1; wd[i] = dd; end
        end else if (aa) begin
            el[i] = 0;
        end else if (el[i] == WW[i] * CC[i]) begin
            mdone[i] = 1;
            if (xf) begin el[i] = 1; wd[i] = dd; end
            else el[i] = 0;
        end else begin
            el[i] = el[i] + 1;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin el[i] = 0; mdone[i] = 0; wd[i] = '0; end
    endtask

    int cyc_n = 0;
    int hs0 = 0, hs1 = 0;
    int fcnt0 = 0, fcnt1 = 0;
    int dq0[$];
    int dq1[$];

    task automatic chk_outputs();
        chk("bit0",   int'(b0),  m_bit(0));
        chk("frame0", int'(f0),  (el[0] != 0) ? 1 : 0);
        chk("done0",  int'(dn0), mdone[0]);
        chk("bit1",   int'(b1),  m_bit(1));
        chk("frame1", int'(f1),  (el[1] != 0) ? 1 : 0);
        chk("done1",  int'(dn1), mdone[1]);
    endtask

    // Called at posedge+1: apply inputs, check ready, take the edge, check outputs.
    task automatic cyc(input logic v0n, input logic a0n, input logic [7:0] d0n,
                       input logic v1n, input logic a1n, input logic [3:0] d1n);
        v0 = v0n; a0 = a0n; d0 = d0n;
        v1 = v1n; a1 = a1n; d1 = d1n;
        #1;
        chk("ready0", int'(r0), m_ready(0, a0n));
        chk("ready1", int'(r1), m_ready(1, a1n));
        @(posedge clk);
        #1;
        m_edge(0, v0n, a0n, d0n);
        m_edge(1, v1n, a1n, {4'b0000, d1n});
        cyc_n++;
        chk_outputs();
        if (f0)  fcnt0++;
        if (f1)  fcnt1++;
        if (dn0) dq0.push_back(cyc_n - hs0 + 1);
        if (dn1) dq1.push_back(cyc_n - hs1 + 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    endtask

    // Entered at posedge+1 (possibly mid-frame); outputs must clear in the same cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; a0 = 1'b0; v1 = 1'b0; a1 = 1'b0;
        m_reset();
        #1;
        chk("rst_ready0", int'(r0), 1);
        chk("rst_ready1", int'(r1), 1);
        chk_outputs();
        @(posedge clk);
        #1;
        chk_outputs();
        rst_n = 1'b1;
    endtask

    task automatic clr_stats();
        fcnt0 = 0; fcnt1 = 0;
        dq0.delete(); dq1.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; a0 = 1'b0; d0 = '0;
        v1 = 1'b0; a1 = 1'b0; d1 = '0;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();
        idle(3);

        // Single frame 8'hA5.
        clr_stats();
        hs0 = cyc_n + 1;
        cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h0);
        idle(36);
        chk("a5_frame_len", fcnt0, 32);
        chk("a5_done_count", dq0.size(), 1);
        if (dq0.size() > 0) chk("a5_done_cycle", dq0[0], 33);

        // Back-to-back 8'hFF then 8'h01 with valid held.
        clr_stats();
        hs0 = cyc_n + 1;
        cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 4'h0);
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 4'h0);
        idle(40);
        chk("b2b_frame_len", fcnt0, 64);
        chk("b2b_done_count", dq0.size(), 2);
        if (dq0.size() > 1) begin
            chk("b2b_done_first", dq0[0], 33);
            chk("b2b_done_second", dq0[1], 65);
        end

        // Abort in cycle 10 of an 8'h3C frame.
        clr_stats();
        hs0 = cyc_n + 1;
        cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 4'h0);
        idle(9);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0);
        chk("abort_frame_off", int'(f0), 0);
        chk("abort_bit_zero", int'(b0), 0);
        idle(30);
        chk("abort_frame_len", fcnt0, 10);
        chk("abort_no_done", dq0.size(), 0);

        // Single-clock bits on the narrow instance.
        clr_stats();
        hs1 = cyc_n + 1;
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0110);
        idle(8);
        chk("c1_frame_len", fcnt1, 4);
        chk("c1_done_count", dq1.size(), 1);
        if (dq1.size() > 0) chk("c1_done_cycle", dq1[0], 5);

        // Reset mid-bit, then a normal frame on both instances.
        cyc(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 4'hF);
        idle(5);
        do_reset();
        clr_stats();
        hs0 = cyc_n + 1;
        hs1 = cyc_n + 1;
        cyc(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 4'h9);
        idle(36);
        chk("post_rst_done0", dq0.size(), 1);
        chk("post_rst_done1", dq1.size(), 1);

        // Random traffic with occasional aborts and resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 24) == 0), 8'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
